// File: rtl/battleship_pkg.sv
// Shared cell codes, FSM state encoding and board types for the battleship screen.
package battleship_pkg;
    localparam int GRID = 5;

    typedef logic [1:0] cell_t;
    localparam cell_t EMPTY  = 2'd0;
    localparam cell_t SHIP   = 2'd1;
    localparam cell_t MISS   = 2'd2;
    localparam cell_t HIT    = 2'd3;
    localparam int    CURSOR = 6;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P_PLACE = 4'd1,
        C_PLACE = 4'd2,
        P_TURN  = 4'd3,
        P_CHECK = 4'd4,
        C_TURN  = 4'd5,
        C_CHECK = 4'd6,
        WIN     = 4'd7,
        LOSE    = 4'd8
    } game_state_t;

    // Drawer-facing matrix, indexed [x][y].
    typedef int board_t [GRID-1:0][GRID-1:0];
    // Internal storage keeps only the 2-bit cell code per cell.
    typedef cell_t [GRID-1:0][GRID-1:0] cells_t;
endpackage

// File: rtl/lfsr5.sv
// 5-bit Fibonacci LFSR for x^5+x^3+1; maximal length, never leaves the nonzero states.
module lfsr5 #(
    parameter logic [4:0] SEED = 5'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [4:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= SEED;
        else if (en) q <= {q[3:0], q[4] ^ q[2]};
    end
endmodule

// File: rtl/battleship_game_ctrl.sv
// Battleship game sequencer: placement, alternating shots, win/lose, and board views
// with cursor overlay for the 5x5 cell drawers.
module battleship_game_ctrl
    import battleship_pkg::*;
#(
    parameter int         N_SHIPS   = 3,
    parameter logic [4:0] LFSR_SEED = 5'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       start,
    output board_t     player_view,
    output board_t     enemy_view,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic [3:0] game_state,
    output logic [3:0] player_hits,
    output logic [3:0] cpu_hits
);
    localparam logic [3:0] NS = 4'(N_SHIPS);

    game_state_t state;
    cells_t      pboard, cboard;
    logic [3:0]  place_cnt;
    logic [4:0]  lfsr, idx;
    logic        cand_ok;
    logic [2:0]  cand_x, cand_y, nx, ny;
    cell_t       cur_c, cand_p, cand_c;

    lfsr5 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .q(lfsr));

    // CPU candidate cell: lfsr-1 spans 0..30, only 0..24 map onto the grid.
    assign idx     = lfsr - 5'd1;
    assign cand_ok = idx < 5'd25;
    assign cand_x  = 3'(idx % 5'd5);
    assign cand_y  = 3'(idx / 5'd5);
    assign cand_p  = pboard[cand_x][cand_y];
    assign cand_c  = cboard[cand_x][cand_y];
    assign cur_c   = cboard[cursor_x][cursor_y];

    assign game_state = state;

    // One saturating move per cycle, priority up > down > left > right.
    always_comb begin
        nx = cursor_x;
        ny = cursor_y;
        if (btn_up) begin
            if (cursor_y != 3'd0) ny = cursor_y - 3'd1;
        end else if (btn_down) begin
            if (cursor_y != 3'd4) ny = cursor_y + 3'd1;
        end else if (btn_left) begin
            if (cursor_x != 3'd0) nx = cursor_x - 3'd1;
        end else if (btn_right) begin
            if (cursor_x != 3'd4) nx = cursor_x + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pboard      <= '0;
            cboard      <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            player_hits <= '0;
            cpu_hits    <= '0;
            place_cnt   <= '0;
        end else begin
            if (state == P_PLACE || state == P_TURN) begin
                cursor_x <= nx;
                cursor_y <= ny;
            end
            case (state)
                IDLE: if (start) begin
                    pboard      <= '0;
                    cboard      <= '0;
                    player_hits <= '0;
                    cpu_hits    <= '0;
                    place_cnt   <= '0;
                    cursor_x    <= '0;
                    cursor_y    <= '0;
                    state       <= P_PLACE;
                end
                // Fire uses the registered (pre-move) cursor.
                P_PLACE: if (btn_fire && pboard[cursor_x][cursor_y] == EMPTY) begin
                    pboard[cursor_x][cursor_y] <= SHIP;
                    place_cnt <= place_cnt + 4'd1;
                    if (place_cnt == NS - 4'd1) begin
                        place_cnt <= '0;
                        state     <= C_PLACE;
                    end
                end
                C_PLACE: if (cand_ok && cand_c == EMPTY) begin
                    cboard[cand_x][cand_y] <= SHIP;
                    place_cnt <= place_cnt + 4'd1;
                    if (place_cnt == NS - 4'd1) begin
                        place_cnt <= '0;
                        cursor_x  <= '0;
                        cursor_y  <= '0;
                        state     <= P_TURN;
                    end
                end
                P_TURN: if (btn_fire) begin
                    if (cur_c == EMPTY) begin
                        cboard[cursor_x][cursor_y] <= MISS;
                        state <= P_CHECK;
                    end else if (cur_c == SHIP) begin
                        cboard[cursor_x][cursor_y] <= HIT;
                        player_hits <= player_hits + 4'd1;
                        state <= P_CHECK;
                    end
                end
                P_CHECK: state <= (player_hits == NS) ? WIN : C_TURN;
                C_TURN: if (cand_ok && (cand_p == EMPTY || cand_p == SHIP)) begin
                    pboard[cand_x][cand_y] <= (cand_p == SHIP) ? HIT : MISS;
                    if (cand_p == SHIP) cpu_hits <= cpu_hits + 4'd1;
                    state <= C_CHECK;
                end
                C_CHECK: state <= (cpu_hits == NS) ? LOSE : P_TURN;
                WIN, LOSE: if (start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int x = 0; x < GRID; x++) begin
            for (int y = 0; y < GRID; y++) begin
                player_view[x][y] = int'(pboard[x][y]);
                enemy_view[x][y]  = (cboard[x][y] == SHIP) ? int'(EMPTY) : int'(cboard[x][y]);
                if (state == P_PLACE && cursor_x == 3'(x) && cursor_y == 3'(y))
                    player_view[x][y] = CURSOR;
                if (state == P_TURN && cursor_x == 3'(x) && cursor_y == 3'(y))
                    enemy_view[x][y] = CURSOR;
            end
        end
    end
endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Randomized self-checking bench for battleship_game_ctrl with a rule-level board model.
module tb_battleship_game_ctrl;
    import battleship_pkg::*;

    localparam int NS = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic btn_fire = 1'b0, start = 1'b0;
    board_t player_view, enemy_view;
    logic [2:0] cursor_x, cursor_y;
    logic [3:0] game_state, player_hits, cpu_hits;

    int n_chk = 0, n_pass = 0;
    int mx = 0, my = 0, m_phits = 0, m_chits = 0;
    int ref_p [5][5];
    int ref_c [5][5];

    battleship_game_ctrl #(.N_SHIPS(NS), .LFSR_SEED(5'h15)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_fire(btn_fire), .start(start),
        .player_view(player_view), .enemy_view(enemy_view),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .game_state(game_state),
        .player_hits(player_hits), .cpu_hits(cpu_hits)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic pulse(input bit u, d, l, r, f, s);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_fire = f; start = s;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0; start = 0;
    endtask

    task automatic goto(input int x, input int y);
        while (mx < x) begin pulse(0,0,0,1,0,0); mx++; end
        while (mx > x) begin pulse(0,0,1,0,0,0); mx--; end
        while (my < y) begin pulse(0,1,0,0,0,0); my++; end
        while (my > y) begin pulse(1,0,0,0,0,0); my--; end
    endtask

    task automatic wait_settle(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (game_state == 4'd3 || game_state == 4'd7 || game_state == 4'd8) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Exactly one new CPU shot per turn: EMPTY->MISS or SHIP->HIT.
    task automatic audit(output int bad);
        int nd = 0;
        bad = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (player_view[x][y] != ref_p[x][y]) begin
                    nd++;
                    if (ref_p[x][y] == 1 && player_view[x][y] == 3) m_chits++;
                    else if (!(ref_p[x][y] == 0 && player_view[x][y] == 2)) bad++;
                    ref_p[x][y] = player_view[x][y];
                end
        if (nd != 1) bad++;
    endtask

    task automatic shoot(input int x, input int y);
        int exp_cell, exp_st, bad;
        bit ok;
        goto(x, y);
        pulse(0,0,0,0,1,0);
        exp_cell = (ref_c[x][y] == 1) ? 3 : 2;
        if (exp_cell == 3) m_phits++;
        ref_c[x][y] = exp_cell;
        n_chk++; if (game_state !== 4'd4) $display("FAIL shot_pcheck: state %0d want 4", game_state); else n_pass++;
        n_chk++; if (enemy_view[x][y] !== exp_cell) $display("FAIL shot_cell: (%0d,%0d)=%0d want %0d", x, y, enemy_view[x][y], exp_cell); else n_pass++;
        n_chk++; if (player_hits !== 4'(m_phits)) $display("FAIL shot_phits: %0d want %0d", player_hits, m_phits); else n_pass++;
        wait_settle(ok);
        n_chk++; if (!ok) $display("FAIL shot_settle: stuck in state %0d want 3/7/8", game_state); else n_pass++;
        if (m_phits == NS) exp_st = 7;
        else begin
            audit(bad);
            n_chk++; if (bad !== 0) $display("FAIL cpu_shot: %0d rule violations want 0", bad); else n_pass++;
            n_chk++; if (cpu_hits !== 4'(m_chits)) $display("FAIL cpu_hits: %0d want %0d", cpu_hits, m_chits); else n_pass++;
            exp_st = (m_chits == NS) ? 8 : 3;
        end
        n_chk++; if (game_state !== 4'(exp_st)) $display("FAIL shot_next: state %0d want %0d", game_state, exp_st); else n_pass++;
    endtask

    task automatic place_ships(input int already);
        int c, sh, ev;
        bit ok;
        for (int k = already; k < NS; k++) begin
            do c = $urandom_range(0, 24); while (ref_p[c % 5][c / 5] != 0);
            goto(c % 5, c / 5);
            pulse(0,0,0,0,1,0);
            ref_p[c % 5][c / 5] = 1;
        end
        n_chk++; if (game_state !== 4'd2) $display("FAIL cplace_enter: state %0d want 2", game_state); else n_pass++;
        wait_settle(ok);
        n_chk++; if (!ok || game_state !== 4'd3) $display("FAIL cplace_done: state %0d want 3", game_state); else n_pass++;
        mx = 0; my = 0;
        n_chk++; if (cursor_x !== 3'd0 || cursor_y !== 3'd0) $display("FAIL cursor_home: (%0d,%0d) want (0,0)", cursor_x, cursor_y); else n_pass++;
        sh = 0; ev = 0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) begin
                ref_c[x][y] = (dut.cboard[x][y] == SHIP) ? 1 : 0;
                sh += ref_c[x][y];
                if (enemy_view[x][y] == 1) ev++;
                if (player_view[x][y] != ref_p[x][y]) ev += 100;
            end
        n_chk++; if (sh !== NS) $display("FAIL cpu_ships: %0d want %0d", sh, NS); else n_pass++;
        n_chk++; if (ev !== 0 || enemy_view[0][0] !== CURSOR) $display("FAIL views_after_place: err %0d corner %0d want 0 and 6", ev, enemy_view[0][0]); else n_pass++;
    endtask

    task automatic new_game();
        pulse(0,0,0,0,0,1);
        n_chk++; if (game_state !== 4'd1) $display("FAIL new_game: state %0d want 1", game_state); else n_pass++;
        repeat (4) pulse(1,0,0,0,0,0);
        repeat (4) pulse(0,0,1,0,0,0);
        mx = 0; my = 0; m_phits = 0; m_chits = 0;
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) begin ref_p[x][y] = 0; ref_c[x][y] = 0; end
    endtask

    task automatic test_reset();
        int nz = 0;
        repeat (3) @(negedge clk);
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) nz += (player_view[x][y] != 0) + (enemy_view[x][y] != 0);
        n_chk++; if (game_state !== 4'd0 || cursor_x !== 3'd0 || cursor_y !== 3'd0) $display("FAIL reset_state: st %0d cur (%0d,%0d) want 0 (0,0)", game_state, cursor_x, cursor_y); else n_pass++;
        n_chk++; if (player_hits !== 4'd0 || cpu_hits !== 4'd0 || nz !== 0) $display("FAIL reset_clear: hits %0d/%0d nonzero cells %0d want 0", player_hits, cpu_hits, nz); else n_pass++;
        n_chk++; if (dut.u_lfsr.q !== 5'h15) $display("FAIL reset_lfsr: %h want 15", dut.u_lfsr.q); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_lfsr();
        int v [32];
        int bad_step = 0, bad_period = 0;
        for (int i = 0; i < 32; i++) begin v[i] = int'(dut.u_lfsr.q); @(negedge clk); end
        for (int i = 0; i < 31; i++)
            if (v[i + 1] != (((v[i] << 1) & 31) | (((v[i] >> 4) ^ (v[i] >> 2)) & 1))) bad_step++;
        for (int i = 0; i < 31; i++) begin
            if (v[i] == 0) bad_period++;
            for (int j = 0; j < i; j++) if (v[i] == v[j]) bad_period++;
        end
        if (v[31] != v[0]) bad_period++;
        n_chk++; if (bad_step !== 0) $display("FAIL lfsr_step: %0d bad steps want 0", bad_step); else n_pass++;
        n_chk++; if (bad_period !== 0) $display("FAIL lfsr_period: %0d errors want 0", bad_period); else n_pass++;
    endtask

    task automatic test_start();
        int nz = 0;
        new_game();
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) nz += (enemy_view[x][y] != 0) + ((x + y != 0) && player_view[x][y] != 0);
        n_chk++; if (player_view[0][0] !== CURSOR || nz !== 0) $display("FAIL start_views: corner %0d stray %0d want 6 and 0", player_view[0][0], nz); else n_pass++;
    endtask

    task automatic test_cursor();
        bit u, d, l, r;
        int bad = 0;
        repeat (6) pulse(0,0,0,1,0,0);
        pulse(0,1,0,0,0,0);
        mx = 4; my = 1;
        n_chk++; if (cursor_x !== 3'd4 || cursor_y !== 3'd1) $display("FAIL cursor_sat: (%0d,%0d) want (4,1)", cursor_x, cursor_y); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            u = 1'($urandom); d = 1'($urandom); l = 1'($urandom); r = 1'($urandom);
            pulse(u, d, l, r, 0, 0);
            if (u) my = (my > 0) ? my - 1 : 0;
            else if (d) my = (my < 4) ? my + 1 : 4;
            else if (l) mx = (mx > 0) ? mx - 1 : 0;
            else if (r) mx = (mx < 4) ? mx + 1 : 4;
            if (cursor_x != 3'(mx) || cursor_y != 3'(my)) bad++;
        end
        n_chk++; if (bad !== 0) $display("FAIL cursor_random: %0d mismatched moves want 0", bad); else n_pass++;
        goto(4, 1);
    endtask

    task automatic test_place();
        int sh = 0;
        pulse(0,0,1,0,1,0);
        mx = 3; ref_p[4][1] = 1;
        n_chk++; if (player_view[4][1] !== 1 || player_view[3][1] !== CURSOR || cursor_x !== 3'd3) $display("FAIL fire_move: cell %0d cur %0d x %0d want 1 6 3", player_view[4][1], player_view[3][1], cursor_x); else n_pass++;
        goto(4, 1);
        pulse(0,0,0,0,1,0);
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) sh += (dut.pboard[x][y] == SHIP);
        n_chk++; if (sh !== 1 || game_state !== 4'd1) $display("FAIL refire_ship: ships %0d st %0d want 1 1", sh, game_state); else n_pass++;
        place_ships(1);
    endtask

    task automatic test_hit_repeat();
        int tx = 0, ty = 0;
        for (int x = 4; x >= 0; x--) for (int y = 4; y >= 0; y--) if (ref_c[x][y] == 1) begin tx = x; ty = y; end
        shoot(tx, ty);
        pulse(0,0,0,0,1,0);
        n_chk++; if (game_state !== 4'd3 || player_hits !== 4'd1) $display("FAIL repeat_shot: st %0d hits %0d want 3 1", game_state, player_hits); else n_pass++;
    endtask

    task automatic test_win();
        int nh = 0;
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) if (ref_c[x][y] == 1) shoot(x, y);
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) nh += (enemy_view[x][y] == 3);
        n_chk++; if (game_state !== 4'd7 || nh !== NS) $display("FAIL win: st %0d hits shown %0d want 7 %0d", game_state, nh, NS); else n_pass++;
        pulse(0,0,0,0,0,1);
        n_chk++; if (game_state !== 4'd0) $display("FAIL win_to_idle: st %0d want 0", game_state); else n_pass++;
    endtask

    task automatic test_lose();
        int tx, ty;
        new_game();
        place_ships(0);
        for (int i = 0; i < 25 && game_state == 4'd3; i++) begin
            tx = -1; ty = -1;
            for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) if (tx < 0 && ref_c[x][y] == 0) begin tx = x; ty = y; end
            for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) if (tx < 0 && ref_c[x][y] == 1) begin tx = x; ty = y; end
            shoot(tx, ty);
        end
        n_chk++; if (game_state !== ((m_phits == NS) ? 4'd7 : 4'd8) || (m_phits != NS && m_chits != NS)) $display("FAIL lose_end: st %0d phits %0d chits %0d", game_state, m_phits, m_chits); else n_pass++;
    endtask

    task automatic test_reset_midgame();
        int nz = 0;
        pulse(0,0,0,0,0,1);
        new_game();
        place_ships(0);
        goto(2, 2);
        pulse(0,0,0,0,1,0);
        n_chk++; if (game_state !== 4'd4) $display("FAIL mid_pcheck: st %0d want 4", game_state); else n_pass++;
        @(negedge clk);
        n_chk++; if (game_state !== 4'd5) $display("FAIL mid_cturn: st %0d want 5", game_state); else n_pass++;
        rst_n = 1'b0;
        #1;
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++)
            nz += (player_view[x][y] != 0) + (enemy_view[x][y] != 0) + (dut.pboard[x][y] != EMPTY) + (dut.cboard[x][y] != EMPTY);
        n_chk++; if (game_state !== 4'd0 || nz !== 0 || player_hits !== 4'd0) $display("FAIL mid_reset: st %0d nonzero %0d hits %0d want 0", game_state, nz, player_hits); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) begin ref_p[x][y] = 0; ref_c[x][y] = 0; end
        test_reset();
        test_lfsr();
        test_start();
        test_cursor();
        test_place();
        test_hit_repeat();
        test_win();
        test_lose();
        test_reset_midgame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/battleship_game_ctrl.md
# battleship_game_ctrl

Game sequencer for the 5x5 battleship screen. Takes one-cycle button pulses and runs ship placement, alternating player/CPU shots and win/lose detection. Owns the two board state arrays and drives them, with a cursor overlay, into the board outline/cell drawers as `int [4:0][4:0]` matrices indexed `[x][y]`. The CPU opponent is a 5-bit LFSR that places ships and chooses shots.

## Interface
- `N_SHIPS`, default 3: single-cell ships per side, 1..8.
- `LFSR_SEED`, default 5'h15: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock (pixel-domain clock; one clock, no CDC).
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced one-cycle pulses; move the cursor.
- `btn_fire`  in  1  one-cycle pulse; place a ship or fire.
- `start`  in  1  one-cycle pulse; leaves IDLE, WIN or LOSE.
- `player_view`  out  int[4:0][4:0]  own board with cursor overlay.
- `enemy_view`  out  int[4:0][4:0]  CPU board with ships hidden and cursor overlay.
- `cursor_x`, `cursor_y`  out  3 each  cursor cell, 0..4.
- `game_state`  out  4  current FSM state encoding.
- `player_hits`, `cpu_hits`  out  4 each  hits landed by each side.

## Operation
- Cell codes: EMPTY=0, SHIP=1, MISS=2, HIT=3, CURSOR=6. The drawers highlight code 6.
- Views:
  - `player_view` = own board, with CURSOR at the cursor cell only in P_PLACE.
  - `enemy_view` = CPU board with SHIP shown as EMPTY, and CURSOR at the cursor cell in P_TURN only.
- Cursor:
  - Saturating at 0 and 4; no wrap.
  - Moves only in P_PLACE and P_TURN.
  - When several direction pulses arrive in the same cycle, priority is up > down > left > right, and only one move is applied.
  - Up decrements y; left decrements x.
- LFSR: x^5+x^3+1, Fibonacci form, advances every cycle in every state. Candidate cell index = lfsr-1, giving 0..30. Index ≥25 is rejected; otherwise x = idx%5, y = idx/5.
- FSM states and transitions:
  - IDLE: on `start`, clear both boards and counters, then go to P_PLACE.
  - P_PLACE: `btn_fire` on an EMPTY own cell writes SHIP. Fire on a SHIP cell is ignored. After the N_SHIPS-th ship, go to C_PLACE.
  - C_PLACE: each cycle, an accepted candidate on an EMPTY CPU cell writes SHIP. After N_SHIPS ships, go to P_TURN and reset the cursor to (0,0).
  - P_TURN: `btn_fire` on a CPU cell:
    - EMPTY → write MISS.
    - SHIP → write HIT and increment `player_hits`.
    - Already MISS or HIT → ignored; stay in P_TURN.
    - Any accepted shot goes to P_CHECK.
  - P_CHECK: if `player_hits`==N_SHIPS go to WIN, else go to C_TURN.
  - C_TURN: each cycle, an accepted candidate on an own cell that is EMPTY or SHIP is shot (MISS or HIT, incrementing `cpu_hits` on HIT), then go to C_CHECK. Rejected or already-shot candidates retry next cycle.
  - C_CHECK: if `cpu_hits`==N_SHIPS go to LOSE, else go to P_TURN.
  - WIN / LOSE: hold the boards; `start` goes to IDLE.
- `start` is ignored outside IDLE, WIN and LOSE.
- Buttons are ignored in every state not listed for them.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - All board cells EMPTY; cursor (0,0); state IDLE; both hit counters 0; LFSR = LFSR_SEED.
  - Views are all 0 except where the overlay rules apply. No overlay is shown in IDLE.
- All outputs are registered or decoded from registers only. Each view is a combinational decode of registered state and is stable for the whole cycle.
- Button pulse at edge n → cursor or board updated and visible after edge n+1 (1-cycle latency).
- Player shot: P_TURN → P_CHECK → C_TURN. The CPU shot takes ≥1 cycle in C_TURN (rejection loop bounded by 31 cycles), then C_CHECK → P_TURN.
- A fire pulse during P_CHECK, C_TURN or C_CHECK is dropped, not queued.
- Move and fire in the same cycle: the shot uses the pre-move cursor and the move is also applied.
- Reset mid-game returns to IDLE within the same cycle as assertion (asynchronous).

## Structure
- Package `battleship_pkg` holds:
  - the cell code constants (EMPTY, SHIP, MISS, HIT, CURSOR);
  - the state enum `game_state_t`;
  - `GRID = 5`;
  - `board_t` typedef (int [4:0][4:0]).
- One sub-module: `lfsr5` (enable, seed parameter, 5-bit output).
- The FSM, boards, counters and view decode live in `battleship_game_ctrl`.

## Test plan
- Reset, then `start`: `game_state`=P_PLACE, all views 0 except `player_view[0][0]`=6.
- Press right ×6, then down ×1: cursor=(4,1), saturated. Fire places SHIP at `player_view[4][1]`. A second fire on the same cell leaves the ship count unchanged.
- Place 3 ships: C_PLACE terminates with exactly 3 SHIP cells in the internal CPU board, 0 visible in `enemy_view`, and state becomes P_TURN.
- Fire at a known CPU ship cell (read through a hierarchical probe): `enemy_view` shows 3 there and `player_hits`=1. Fire again on that cell: no state change.
- Hit all 3 CPU ships before the CPU wins, using a forced seed: after the 3rd hit, P_CHECK → WIN. Then `start` → IDLE.
- Fire in P_TURN, then assert `rst_n`=0 in C_TURN: state is IDLE and the boards are cleared immediately.
